// File: rtl/logic_eval_pipe.sv
// logic_eval_pipe: two-stage elastic pipeline evaluating g/h/f over WIDTH-bit operands
// with a saturating count of transferred non-zero results.
module logic_eval_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] x3,
  input  logic [WIDTH-1:0] x4,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic [WIDTH-1:0] g,
  output logic [WIDTH-1:0] h,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] match_cnt
);
  logic             s1_valid;
  logic [WIDTH-1:0] r1, r2, r3, r4;
  logic [1:0]       r_mode;
  logic             s2_load, accept;
  logic [WIDTH-1:0] g_n, h_n, f_n;

  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign accept   = in_valid && in_ready;

  always_comb begin
    g_n = (r1 & r3) | (r2 & r4);
    h_n = (r1 | r3) & (r2 | r4);
    f_n = r_mode == 2'b00 ? (g_n | h_n) :
          r_mode == 2'b01 ? (g_n & h_n) :
          r_mode == 2'b10 ? (g_n ^ h_n) : ~(g_n | h_n);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      r1        <= '0;
      r2        <= '0;
      r3        <= '0;
      r4        <= '0;
      r_mode    <= '0;
      out_valid <= 1'b0;
      f         <= '0;
      g         <= '0;
      h         <= '0;
      match_cnt <= '0;
    end else begin
      if (accept) begin
        r1       <= x1;
        r2       <= x2;
        r3       <= x3;
        r4       <= x4;
        r_mode   <= mode;
        s1_valid <= 1'b1;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          f <= f_n;
          g <= g_n;
          h <= h_n;
        end
      end
      // clear wins over a same-cycle counting transfer
      if (cnt_clr)
        match_cnt <= '0;
      else if (out_valid && out_ready && |f && match_cnt != '1)
        match_cnt <= match_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_logic_eval_pipe.sv
// tb_logic_eval_pipe: vector table, directed corner sequences and a randomized
// run checked against an in-order scoreboard model.
module tb_logic_eval_pipe;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready, cnt_clr;
  logic [3:0] x1, x2, x3, x4;
  logic [1:0] mode;
  logic       in_ready, out_valid;
  logic [3:0] f, g, h;
  logic [1:0] match_cnt;

  int checks = 0;
  int errors = 0;

  logic_eval_pipe #(.WIDTH(4), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .x2(x2), .x3(x3), .x4(x4), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .f(f), .g(g), .h(h), .cnt_clr(cnt_clr), .match_cnt(match_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] f, g, h;
    int         acc_cyc;
  } ent_t;

  typedef struct {
    logic [3:0] x1, x2, x3, x4;
    logic [1:0] mode;
    logic [3:0] f, g, h;
  } vec_t;

  ent_t q[$];
  int   cyc = 0;
  int   cnt_m = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t model(input logic [3:0] a, b, c, d, input logic [1:0] m, input int ac);
    ent_t e;
    e.g = (a & c) | (b & d);
    e.h = (a | c) & (b | d);
    case (m)
      2'd0: e.f = e.g | e.h;
      2'd1: e.f = e.g & e.h;
      2'd2: e.f = e.g ^ e.h;
      default: e.f = ~(e.g | e.h);
    endcase
    e.acc_cyc = ac;
    return e;
  endfunction

  // Scoreboard: items leave in acceptance order; an item is visible two edges after its accept.
  always @(negedge clk) begin
    logic ov_e, ir_e, xfer, acc;
    cyc++;
    if (!rst_n) begin
      q.delete();
      cnt_m = 0;
      chk("rst_in_ready", in_ready, 1);
    end else begin
      ov_e = q.size() > 0 && (cyc - q[0].acc_cyc) >= 2;
      ir_e = !(q.size() == 2 && !out_ready);
      chk("out_valid", out_valid, ov_e);
      chk("in_ready", in_ready, ir_e);
      chk("match_cnt", match_cnt, cnt_m);
      if (ov_e) begin
        chk("f", f, q[0].f);
        chk("g", g, q[0].g);
        chk("h", h, q[0].h);
      end
      xfer = ov_e && out_ready;
      acc  = in_valid && ir_e;
      if (cnt_clr) cnt_m = 0;
      else if (xfer && q[0].f != 0 && cnt_m < 3) cnt_m++;
      if (xfer) void'(q.pop_front());
      if (acc) q.push_back(model(x1, x2, x3, x4, mode, cyc));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] a, b, c, d, input logic [1:0] m);
    in_valid = v; x1 = a; x2 = b; x3 = c; x4 = d; mode = m;
  endtask

  task automatic drive_rand(input logic v);
    drive(v, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 2'($urandom));
  endtask

  vec_t vecs[4];
  int   cnt_exp[5] = '{1, 2, 3, 3, 3};
  int   ir_exp[5]  = '{1, 1, 0, 0, 0};
  logic [3:0] fs, gs, hs;

  initial begin
    rst_n = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
    drive(1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0);
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_fgh", {f, g, h}, 0);
    chk("reset_cnt", match_cnt, 0);
    chk("reset_in_ready", in_ready, 1);
    step(); step();
    rst_n = 1'b1;

    // Function table: fixed operands, every mode
    vecs[0] = '{4'b1010, 4'b0101, 4'b1100, 4'b0110, 2'd0, 4'b1110, 4'b1100, 4'b0110};
    vecs[1] = '{4'b1010, 4'b0101, 4'b1100, 4'b0110, 2'd1, 4'b0100, 4'b1100, 4'b0110};
    vecs[2] = '{4'b1010, 4'b0101, 4'b1100, 4'b0110, 2'd2, 4'b1010, 4'b1100, 4'b0110};
    vecs[3] = '{4'b1010, 4'b0101, 4'b1100, 4'b0110, 2'd3, 4'b0001, 4'b1100, 4'b0110};
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].x1, vecs[i].x2, vecs[i].x3, vecs[i].x4, vecs[i].mode);
      step();
      in_valid = 1'b0;
      chk("vec_not_early", out_valid, 0);
      step();
      chk("vec_valid", out_valid, 1);
      chk("vec_f", f, vecs[i].f);
      chk("vec_g", g, vecs[i].g);
      chk("vec_h", h, vecs[i].h);
      step();
    end

    // Asynchronous reset with two entries in flight
    out_ready = 1'b0;
    drive_rand(1'b1); step();
    drive_rand(1'b1); step();
    in_valid = 1'b0;
    chk("pre_rst_full", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_fgh", {f, g, h}, 0);
    chk("arst_cnt", match_cnt, 0);
    chk("arst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_empty", out_valid, 0);
    step();
    chk("post_rst_empty2", out_valid, 0);

    // Streaming: 8 back-to-back sets
    for (int i = 0; i < 8; i++) begin
      drive_rand(1'b1);
      chk("stream_in_ready", in_ready, 1);
      step();
      if (i > 0) chk("stream_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_last", out_valid, 1);
    step();
    chk("stream_done", out_valid, 0);

    // Backpressure: consumer stalls for 5 cycles
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_rand(1'b1);
      chk("bp_in_ready", in_ready, ir_exp[i]);
      step();
      if (i == 1) begin fs = f; gs = g; hs = h; end
    end
    chk("bp_hold", {f, g, h}, {fs, gs, hs});
    chk("bp_valid", out_valid, 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp_second", out_valid, 1);
    step();
    chk("bp_drained", out_valid, 0);

    // Counter saturation at 3 with CNT_W = 2
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    chk("cnt_cleared", match_cnt, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 4'b1010, 4'b0101, 4'b1100, 4'b0110, 2'd0);
      step(); in_valid = 1'b0; step(); step();
      chk("cnt_sat", match_cnt, cnt_exp[i]);
    end
    drive(1'b1, 4'h0, 4'h0, 4'h0, 4'h0, 2'd0);
    step(); in_valid = 1'b0; step(); step();
    chk("cnt_zero_f", match_cnt, 3);
    drive(1'b1, 4'b1010, 4'b0101, 4'b1100, 4'b0110, 2'd0);
    step(); in_valid = 1'b0; step();
    cnt_clr = 1'b1; step(); cnt_clr = 1'b0;
    chk("cnt_clr_prio", match_cnt, 0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive_rand(1'($urandom));
      out_ready = 1'($urandom);
      cnt_clr = ($urandom_range(0, 19) == 0);
      step();
    end
    in_valid = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
    step(); step(); step();
    chk("final_drain", q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
